// File: rtl/if_id_stage.sv
// -----------------------------------------------------------------------------
// if_id_stage
//
// Fetch-to-decode pipeline boundary. Captures the PC of the fetched
// instruction together with the instruction word and presents both to decode
// through a valid/ready handshake. A two-entry buffer (main + skid) absorbs one
// cycle of decode backpressure so a fetch accepted while decode stalls is not
// lost. A flush discards everything buffered plus whatever is offered that
// cycle, so wrong-path instructions never reach decode after a redirect.
//
// Ports
//   clk           rising-edge clock
//   rst           synchronous, active-high reset
//   in_valid      upstream offers a PC/instruction pair this cycle
//   in_ready      stage can accept a pair this cycle (registered)
//   in_pc         PC of the fetched instruction (PC register Q)
//   in_instr      instruction word from instruction memory
//   flush         discard all buffered and incoming entries
//   out_valid     out_pc/out_instr hold a valid entry (registered)
//   out_ready     decode consumes the presented entry this cycle
//   out_pc        PC of the presented instruction (registered)
//   out_pc_plus4  out_pc + 4, modulo 2^N (registered)
//   out_instr     presented instruction; NOP whenever out_valid=0 (registered)
// -----------------------------------------------------------------------------
module if_id_stage #(
  parameter int          N   = 32,
  parameter logic [N-1:0] NOP = N'(32'h0000_0013)  // addi x0,x0,0
) (
  input  logic         clk,
  input  logic         rst,
  input  logic         in_valid,
  output logic         in_ready,
  input  logic [N-1:0] in_pc,
  input  logic [N-1:0] in_instr,
  input  logic         flush,
  output logic         out_valid,
  input  logic         out_ready,
  output logic [N-1:0] out_pc,
  output logic [N-1:0] out_pc_plus4,
  output logic [N-1:0] out_instr
);

  // EMPTY: nothing held.  ONE: main holds the presented entry.
  // TWO: main presented, skid holds the next entry, input closed.
  typedef enum logic [1:0] {
    S_EMPTY = 2'd0,
    S_ONE   = 2'd1,
    S_TWO   = 2'd2
  } state_e;

  state_e       state_q;

  // Main register: drives the outputs directly.
  logic [N-1:0] main_pc_q;
  logic [N-1:0] main_pc_plus4_q;
  logic [N-1:0] main_instr_q;
  logic         out_valid_q;
  logic         in_ready_q;

  // Skid register: holds the entry accepted while decode was stalled.
  logic [N-1:0] skid_pc_q;
  logic [N-1:0] skid_instr_q;

  // Handshake events and precomputed next values for the main register.
  logic         acc;
  logic         tk;
  logic [N-1:0] in_pc_plus4_d;
  logic [N-1:0] skid_pc_plus4_d;

  // NOTE: every always_comb output is assigned on every path (here
  // unconditionally); a missing assignment on some path infers a latch.
  always_comb begin
    acc             = in_valid & in_ready_q;
    tk              = out_valid_q & out_ready;
    // Carry out of the top bit is dropped: PC+4 wraps silently.
    in_pc_plus4_d   = in_pc + N'(4);
    skid_pc_plus4_d = skid_pc_q + N'(4);
  end

  // Single-process FSM: state, handshake flags and datapath registers all
  // update together so every output comes straight from a flop and there is
  // no combinational path from out_ready to in_ready.
  // NOTE: sequential state uses non-blocking assignments only, so every flop
  // samples values from before the edge regardless of statement order.
  always_ff @(posedge clk) begin
    if (rst) begin
      // NOTE: the datapath registers are reset here deliberately: outputs
      // have defined post-reset values (PC 0, PC+4 = 4, NOP) and the skid
      // buffer is cleared so no stale data survives a reset.
      state_q         <= S_EMPTY;
      out_valid_q     <= 1'b0;
      in_ready_q      <= 1'b1;
      main_pc_q       <= '0;
      main_pc_plus4_q <= N'(4);
      main_instr_q    <= NOP;
      skid_pc_q       <= '0;
      skid_instr_q    <= '0;
    end else if (flush) begin
      // Drop everything, including any pair offered this cycle. An entry
      // taken by decode this same cycle has already been consumed. The PC
      // fields keep their last values; only the instruction reverts to NOP.
      state_q      <= S_EMPTY;
      out_valid_q  <= 1'b0;
      in_ready_q   <= 1'b1;
      main_instr_q <= NOP;
    end else begin
      unique case (state_q)
        S_EMPTY: begin
          if (acc) begin
            main_pc_q       <= in_pc;
            main_pc_plus4_q <= in_pc_plus4_d;
            main_instr_q    <= in_instr;
            out_valid_q     <= 1'b1;
            state_q         <= S_ONE;
          end
        end

        S_ONE: begin
          if (acc && tk) begin
            // Decode takes the current entry; the new one replaces it.
            main_pc_q       <= in_pc;
            main_pc_plus4_q <= in_pc_plus4_d;
            main_instr_q    <= in_instr;
          end else if (acc) begin
            // Decode stalled: park the new entry and close the input.
            skid_pc_q    <= in_pc;
            skid_instr_q <= in_instr;
            in_ready_q   <= 1'b0;
            state_q      <= S_TWO;
          end else if (tk) begin
            out_valid_q  <= 1'b0;
            main_instr_q <= NOP;
            state_q      <= S_EMPTY;
          end
        end

        S_TWO: begin
          // Input is closed here, so only a take can move the state.
          if (tk) begin
            main_pc_q       <= skid_pc_q;
            main_pc_plus4_q <= skid_pc_plus4_d;
            main_instr_q    <= skid_instr_q;
            in_ready_q      <= 1'b1;
            state_q         <= S_ONE;
          end
        end

        default: begin
          // Unreachable encoding: recover to a clean empty stage.
          state_q      <= S_EMPTY;
          out_valid_q  <= 1'b0;
          in_ready_q   <= 1'b1;
          main_instr_q <= NOP;
        end
      endcase
    end
  end

  assign in_ready     = in_ready_q;
  assign out_valid    = out_valid_q;
  assign out_pc       = main_pc_q;
  assign out_pc_plus4 = main_pc_plus4_q;
  assign out_instr    = main_instr_q;

endmodule
